// File: rtl/pmac_unit.sv
// rtl/pmac_unit.sv - multi-lane multiply-accumulate over a window of beats
// Signed/unsigned lanes, saturating or wrapping accumulator, valid/ready in and out.
module pmac_unit #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          win_len_i,
    input  logic                      signed_mode_i,
    input  logic                      sat_en_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES*DATA_W-1:0]   img_pixels_i,
    input  logic [LANES*DATA_W-1:0]   filter_values_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ACC_W-1:0]          out_o,
    output logic                      overflow_o,
    output logic                      busy_o
);

    localparam int SUM_W = 2 * DATA_W + $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_e;
    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [ACC_W:0]   ext_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               signed_q, signed_d;
    logic               sat_q, sat_d;
    logic [SUM_W-1:0]   prod_q, prod_d;
    logic               prod_valid_q, prod_valid_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    sum_t               lane_sum;
    logic signed [DATA_W:0] a_x, b_x;
    ext_t               prod_ext, acc_ext, acc_sum;
    logic               step_ovf;
    logic [ACC_W-1:0]   sat_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            signed_q     <= 1'b0;
            sat_q        <= 1'b0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            signed_q     <= signed_d;
            sat_q        <= sat_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && (win_len_i != '0)) state_d = S_ACC;
            S_ACC:   if (accept && (rem_q == CNT_W'(1))) state_d = S_DRAIN;
            S_DRAIN: state_d = S_HOLD;
            S_HOLD:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == S_ACC);
        out_valid_o = (state_q == S_HOLD);
        busy_o      = (state_q != S_IDLE);
        out_o       = acc_q;
        overflow_o  = ovf_q;
    end

    assign accept = in_valid_i && in_ready_o;

    // Modular arithmetic in SUM_W bits is exact: the true lane sum always fits.
    always_comb begin
        lane_sum = '0;
        a_x      = '0;
        b_x      = '0;
        for (int i = 0; i < LANES; i++) begin
            a_x = {signed_q & img_pixels_i[i*DATA_W + DATA_W-1], img_pixels_i[i*DATA_W +: DATA_W]};
            b_x = {signed_q & filter_values_i[i*DATA_W + DATA_W-1], filter_values_i[i*DATA_W +: DATA_W]};
            lane_sum = lane_sum + sum_t'(a_x) * sum_t'(b_x);
        end
    end

    always_comb begin
        prod_ext = signed_q ? ext_t'($signed(prod_q)) : ext_t'({1'b0, prod_q});
        acc_ext  = signed_q ? ext_t'($signed(acc_q))  : ext_t'({1'b0, acc_q});
        acc_sum  = acc_ext + prod_ext;
        step_ovf = signed_q ? (acc_sum[ACC_W] ^ acc_sum[ACC_W-1]) : acc_sum[ACC_W];
        if (!signed_q)
            sat_val = '1;
        else if (acc_sum[ACC_W])
            sat_val = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sat_val = {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_comb begin
        rem_d        = rem_q;
        signed_d     = signed_q;
        sat_d        = sat_q;
        prod_d       = prod_q;
        prod_valid_d = 1'b0;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        if (state_q == S_IDLE && start_i && (win_len_i != '0)) begin
            rem_d    = win_len_i;
            signed_d = signed_mode_i;
            sat_d    = sat_en_i;
            acc_d    = '0;
            ovf_d    = 1'b0;
        end
        if (accept) begin
            prod_d       = lane_sum;
            prod_valid_d = 1'b1;
            rem_d        = rem_q - CNT_W'(1);
        end
        if (prod_valid_q) begin
            acc_d = (step_ovf && sat_q) ? sat_val : acc_sum[ACC_W-1:0];
            ovf_d = ovf_q | step_ovf;
        end
    end

endmodule

// File: tb/tb_pmac_unit.sv
// tb/tb_pmac_unit.sv - directed self-checking bench for pmac_unit
module tb_pmac_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  win_len_i;
    logic        signed_mode_i;
    logic        sat_en_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] img_pixels_i;
    logic [31:0] filter_values_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [19:0] out_o;
    logic        overflow_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    pmac_unit #(.DATA_W(8), .LANES(4), .ACC_W(20), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .win_len_i(win_len_i),
        .signed_mode_i(signed_mode_i), .sat_en_i(sat_en_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .img_pixels_i(img_pixels_i), .filter_values_i(filter_values_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_o(out_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic run_window(input logic [7:0] wl, input logic sm, input logic se,
                              input logic [31:0] pix, input logic [31:0] flt,
                              input logic [15:0] gaps, input int hold,
                              output logic [19:0] res, output logic ovf, output int lat,
                              output bit stable, output bit rdy_in_hold,
                              output bit start_ign, output bit tmo);
        int naccept;
        int k;
        tmo = 0; stable = 1; rdy_in_hold = 0; start_ign = 1;
        win_len_i = wl; signed_mode_i = sm; sat_en_i = se;
        img_pixels_i = pix; filter_values_i = flt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        naccept = 0; k = 0;
        while (naccept < int'(wl) && k < 200) begin
            in_valid_i = !gaps[k % 16];
            if (in_valid_i && in_ready_o) naccept++;
            tick();
            k++;
        end
        in_valid_i = 1'b0;
        if (naccept < int'(wl)) tmo = 1;
        lat = 1;
        while (!out_valid_o && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid_o) tmo = 1;
        res = out_o;
        ovf = overflow_o;
        for (int h = 0; h < hold; h++) begin
            start_i = 1'b1;
            tick();
            if (out_o !== res || overflow_o !== ovf || out_valid_o !== 1'b1) stable = 0;
            if (in_ready_o) rdy_in_hold = 1;
        end
        out_ready_i = 1'b1;
        start_i = (hold > 0);
        tick();
        out_ready_i = 1'b0;
        start_i = 1'b0;
        if (busy_o || out_valid_o) start_ign = 0;
        tick();
        if (busy_o) start_ign = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
        checks++; if (out_o !== 20'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", out_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_unsigned_basic();
        logic [19:0] res; logic ovf; int lat; bit st, rh, si, tmo;
        run_window(8'd2, 1'b0, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 16'h0, 0,
                   res, ovf, lat, st, rh, si, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL unsigned_timeout got %b exp 0", tmo); end
        checks++; if (res !== 20'd140) begin errors++; $display("FAIL unsigned_out got %0d exp 140", res); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL unsigned_ovf got %b exp 0", ovf); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL unsigned_latency got %0d exp 2", lat); end
        checks++; if (out_o !== 20'd140) begin errors++; $display("FAIL unsigned_idle_readback got %0d exp 140", out_o); end
    endtask

    task automatic test_signed();
        logic [19:0] res; logic ovf; int lat; bit st, rh, si, tmo;
        run_window(8'd3, 1'b1, 1'b0, pack4(8'h80, 8'h80, 8'h80, 8'h80),
                   pack4(8'h7F, 8'h7F, 8'h7F, 8'h7F), 16'h0, 0, res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'hD0600) begin errors++; $display("FAIL signed_out got %h exp d0600", res); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL signed_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_saturate();
        logic [19:0] res; logic ovf; int lat; bit st, rh, si, tmo;
        logic [31:0] ff;
        ff = 32'hFFFF_FFFF;
        run_window(8'd16, 1'b0, 1'b1, ff, ff, 16'h0, 0, res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'd1048575) begin errors++; $display("FAIL sat_out got %0d exp 1048575", res); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", ovf); end
        run_window(8'd16, 1'b0, 1'b0, ff, ff, 16'h0, 0, res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'd1015872) begin errors++; $display("FAIL wrap_out got %0d exp 1015872", res); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b exp 1", ovf); end
        run_window(8'd16, 1'b1, 1'b1, pack4(8'h80, 8'h80, 8'h80, 8'h80),
                   pack4(8'h7F, 8'h7F, 8'h7F, 8'h7F), 16'h0, 0, res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'h80000) begin errors++; $display("FAIL signed_sat_out got %h exp 80000", res); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL signed_sat_ovf got %b exp 1", ovf); end
        run_window(8'd16, 1'b1, 1'b0, pack4(8'h80, 8'h80, 8'h80, 8'h80),
                   pack4(8'h7F, 8'h7F, 8'h7F, 8'h7F), 16'h0, 0, res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'd8192) begin errors++; $display("FAIL signed_wrap_out got %0d exp 8192", res); end
    endtask

    task automatic test_handshake();
        logic [19:0] res; logic ovf; int lat; bit st, rh, si, tmo;
        run_window(8'd4, 1'b0, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 16'h0, 0,
                   res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'd280) begin errors++; $display("FAIL gapfree_out got %0d exp 280", res); end
        run_window(8'd4, 1'b0, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 16'b0000_0000_1011_0101, 5,
                   res, ovf, lat, st, rh, si, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL gaps_timeout got %b exp 0", tmo); end
        checks++; if (res !== 20'd280) begin errors++; $display("FAIL gaps_out got %0d exp 280", res); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL gaps_ovf got %b exp 0", ovf); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL hold_stable got %b exp 1", st); end
        checks++; if (rh !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b exp 0", rh); end
        checks++; if (si !== 1'b1) begin errors++; $display("FAIL hold_start_ignored got %b exp 1", si); end
    endtask

    task automatic test_back_to_back();
        win_len_i = 8'd3; signed_mode_i = 1'b0; sat_en_i = 1'b0;
        img_pixels_i = pack4(1, 2, 3, 4); filter_values_i = pack4(5, 6, 7, 8);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_start got %b exp 1", in_ready_o); end
        in_valid_i = 1'b1;
        tick(); tick(); tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %b exp 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_drain_ready got %b exp 0", in_ready_o); end
        out_ready_i = 1'b1;
        tick();
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b exp 1", out_valid_o); end
        checks++; if (out_o !== 20'd210) begin errors++; $display("FAIL b2b_out got %0d exp 210", out_o); end
        tick();
        out_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_period_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_reset_midwindow();
        logic [19:0] res; logic ovf; int lat; bit st, rh, si, tmo;
        bit saw_valid;
        win_len_i = 8'd4; signed_mode_i = 1'b0; sat_en_i = 1'b0;
        img_pixels_i = pack4(1, 2, 3, 4); filter_values_i = pack4(5, 6, 7, 8);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        tick(); tick();
        in_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready_o); end
        checks++; if (out_o !== 20'd0) begin errors++; $display("FAIL midrst_out got %0d exp 0", out_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", overflow_o); end
        saw_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_o) saw_valid = 1;
            tick();
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", saw_valid); end
        run_window(8'd1, 1'b0, 1'b0, pack4(10, 20, 30, 40), pack4(1, 1, 1, 1), 16'h0, 0,
                   res, ovf, lat, st, rh, si, tmo);
        checks++; if (res !== 20'd100) begin errors++; $display("FAIL midrst_fresh_out got %0d exp 100", res); end
    endtask

    task automatic test_zero_len();
        win_len_i = 8'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zerolen_busy got %b exp 0", busy_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL zerolen_in_ready got %b exp 0", in_ready_o); end
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zerolen_busy_later got %b exp 0", busy_o); end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; win_len_i = '0; signed_mode_i = 1'b0; sat_en_i = 1'b0;
        in_valid_i = 1'b0; img_pixels_i = '0; filter_values_i = '0; out_ready_i = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_saturate();
        test_handshake();
        test_back_to_back();
        test_reset_midwindow();
        test_zero_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
